// File: rtl/nibble_serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for nibble_serial_adder_ctrl.
//   master : requester side, drives start/A/B/SUB/C_in and observes the result
//   slave  : adder side, samples the request and drives busy/done/SUM/C_out/OVF
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             SUB;
    logic             C_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] SUM;
    logic             C_out;
    logic             OVF;

    modport master (
        output start, A, B, SUB, C_in,
        input  busy, done, SUM, C_out, OVF
    );

    modport slave (
        input  start, A, B, SUB, C_in,
        output busy, done, SUM, C_out, OVF
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder/subtractor built around one 4-bit ripple slice.
// Operands are captured on an accepted start, then one nibble per clock is
// added LSB first, with a registered carry linking the passes.
// Ports:
//   CLK   : rising-edge clock
//   RST_n : synchronous active-low reset
//   bus   : slave side of nibble_serial_adder_ctrl_if
//           (start/A/B/SUB/C_in in, busy/done/SUM/C_out/OVF out, all outputs registered)
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                        CLK,
    input  logic                        RST_n,
    nibble_serial_adder_ctrl_if.slave   bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB);
    localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The shared 4-bit ripple-carry slice: returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] ripple_addr_4_bit(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       cin
    );
        logic [3:0] z;
        logic       c;
        c = cin;
        for (int i = 0; i < 4; i++) begin
            z[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, z};
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic             last_s;
    logic [3:0]       x_s;
    logic [3:0]       y_s;
    logic [3:0]       z_s;
    logic             add_cout_s;
    logic             ovf_s;

    // Slice inputs: current nibble of each operand plus the linking carry.
    always_comb begin
        x_s = a_r[{cnt_r, 2'b00} +: 4];
        y_s = b_r[{cnt_r, 2'b00} +: 4];
        {add_cout_s, z_s} = ripple_addr_4_bit(x_s, y_s, carry_r);
        // Carry into the MSB recovered from the MSB sum bit of the last pass.
        ovf_s = (x_s[3] ^ y_s[3] ^ z_s[3]) ^ add_cout_s;
    end

    // Next-state logic. busy_r lags the state by one cycle, so gating on it
    // keeps a start in the done-reporting cycle from being accepted.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        last_s      = (cnt_r == LAST_NIB);
        case (state_r)
            IDLE: begin
                if (bus.start && !busy_r) begin
                    accept_s    = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, nibble accumulation and registered status outputs.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            cnt_r   <= '0;
            carry_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            busy_r <= (state_r != IDLE);
            done_r <= (state_r == DONE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= bus.A;
                        b_r     <= bus.SUB ? ~bus.B : bus.B;
                        carry_r <= bus.SUB ? 1'b1 : bus.C_in;
                        cnt_r   <= '0;
                    end
                end
                RUN: begin
                    sum_r[{cnt_r, 2'b00} +: 4] <= z_s;
                    carry_r                    <= add_cout_s;
                    if (last_s) begin
                        c_out_r <= add_cout_s;
                        ovf_r   <= ovf_s;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.SUM   = sum_r;
    assign bus.C_out = c_out_r;
    assign bus.OVF   = ovf_r;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
module tb_nibble_serial_adder_ctrl;
    localparam int WIDTH = 16;

    logic CLK   = 1'b0;
    logic RST_n = 1'b0;
    always #5 CLK = ~CLK;

    nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus)
    );

    int   cmp_cnt = 0;
    int   mis_cnt = 0;
    logic prev_c  = 1'b0;
    logic prev_o  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            mis_cnt++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic st, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic cin);
        bus.start = st;
        bus.A     = a;
        bus.B     = b;
        bus.SUB   = sub;
        bus.C_in  = cin;
    endtask

    // Full operation: start at edge T, done expected after edge T+5.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic cin,
                          input logic [15:0] e_sum, input logic e_c, input logic e_o);
        int n;
        drive(1'b1, a, b, sub, cin);
        tick();                                   // edge T
        bus.start = 1'b0;
        tick();                                   // edge T+1
        n = 1;
        check({tag, "_busy_T1"}, {31'd0, bus.busy}, 32'd1);
        check({tag, "_cout_hold"}, {30'd0, bus.C_out, bus.OVF}, {30'd0, prev_c, prev_o});
        while (bus.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 32'd5);
        check({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd1);
        check({tag, "_sum"}, {16'd0, bus.SUM}, {16'd0, e_sum});
        check({tag, "_cout"}, {31'd0, bus.C_out}, {31'd0, e_c});
        check({tag, "_ovf"}, {31'd0, bus.OVF}, {31'd0, e_o});
        tick();
        check({tag, "_done_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
        prev_c = e_c;
        prev_o = e_o;
    endtask

    initial begin
        int n;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        RST_n = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_sum", {16'd0, bus.SUM}, 32'd0);
        check("rst_flags", {30'd0, bus.C_out, bus.OVF}, 32'd0);
        RST_n = 1'b1;
        tick();

        run_op("add_small", 16'h0001, 16'h0002, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b0);
        run_op("add_ripple", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // Starts during RUN and during the done cycle must be ignored.
        drive(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0);
        tick();                                   // edge T
        bus.start = 1'b0;
        tick();                                   // edge T+1
        drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        tick();                                   // edge T+2 samples the ignored start
        bus.start = 1'b0;
        n = 2;
        while (bus.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("ign_latency", n, 32'd5);
        check("ign_sum", {16'd0, bus.SUM}, 32'h0000_2345);
        drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        tick();                                   // edge T+6 samples the ignored start
        bus.start = 1'b0;
        check("ign_idle", {30'd0, bus.done, bus.busy}, 32'd0);
        tick();
        check("ign_not_accepted", {31'd0, bus.busy}, 32'd0);
        check("ign_sum_hold", {16'd0, bus.SUM}, 32'h0000_2345);
        prev_c = 1'b0;
        prev_o = 1'b0;

        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Reset mid-operation, then start while reset is low.
        drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        tick();                                   // edge T
        bus.start = 1'b0;
        tick();                                   // edge T+1
        RST_n = 1'b0;
        tick();                                   // edge T+2
        check("mid_rst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
        check("mid_rst_sum", {16'd0, bus.SUM}, 32'd0);
        check("mid_rst_flags", {30'd0, bus.C_out, bus.OVF}, 32'd0);
        drive(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0);
        tick();                                   // start dropped under reset
        bus.start = 1'b0;
        RST_n = 1'b1;
        tick();
        check("rst_wins_start", {30'd0, bus.busy, bus.done}, 32'd0);
        tick();
        check("rst_no_done", {30'd0, bus.busy, bus.done}, 32'd0);
        prev_c = 1'b0;
        prev_o = 1'b0;

        run_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ge", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that time-shares one ripple_addr_4_bit slice to add or subtract WIDTH-bit operands, one nibble per clock, LSB nibble first. A registered carry links the nibbles. Operands are captured on a start/busy/done handshake. The block targets area-constrained datapaths that need wide add/sub without a WIDTH-bit ripple chain.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
NIB, WIDTH/4, number of nibble passes (localparam, derived, not overridable).

Ports:
CLK  input  1  rising-edge clock
RST_n  input  1  synchronous active-low reset
start  input  1  request a new operation; accepted only when busy=0
A  input  WIDTH  operand A, sampled on accepted start
B  input  WIDTH  operand B, sampled on accepted start
SUB  input  1  0: A+B+C_in; 1: A-B (A + ~B + 1; C_in ignored), sampled on accepted start
C_in  input  1  carry-in for add, sampled on accepted start
busy  output  1  high while an operation is in progress or being reported
done  output  1  one-cycle pulse: SUM/C_out/OVF valid
SUM  output  WIDTH  result, held until the next accepted start
C_out  output  1  final carry; for SUB, 1 = no borrow (A >= B unsigned)
OVF  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset and clocking:
  - One clock domain, CLK.
  - Reset is synchronous, active-low, on RST_n.
  - Reset is sampled only on the CLK rising edge.
- Reset values:
  - State = IDLE.
  - busy=0, done=0, SUM=0, C_out=0, OVF=0.
  - Internal nibble counter, carry register and operand registers = 0.
- Datapath: one ripple_addr_4_bit instance.
  - X = current nibble of the operand-A register.
  - Y = current nibble of the operand-B register (already inverted if SUB).
  - C_in = carry register.
- IDLE state:
  - busy=0.
  - On start=1: latch A; latch B (or ~B if SUB=1); carry register = SUB ? 1 : C_in; counter = 0.
  - Then go to RUN.
  - start=0: remain in IDLE.
- RUN state (busy=1):
  - Each cycle, write adder Z into SUM[4k+3:4k], where k = counter.
  - Carry register <= adder C_out.
  - When k = NIB-1: capture the carry into bit WIDTH-1 (for OVF) and go to DONE.
  - Otherwise counter increments.
- DONE state (busy=1, done=1 for exactly one cycle):
  - C_out and OVF are valid here.
  - Return to IDLE unconditionally.
- Latency:
  - start sampled at edge T.
  - RUN occupies edges T+1 .. T+NIB.
  - done=1 during the cycle following edge T+NIB+1; with WIDTH=16, done is observed after edge T+5.
  - Next start is accepted at the earliest on the cycle after done.
- start while busy=1 (RUN or DONE): ignored, with no effect on operands or result.
- During RUN, SUM shows partially updated nibbles. It is valid only when done=1, and in IDLE after done.
- C_out and OVF update only on entry to DONE; they hold their previous values during RUN.
- Simultaneous start and RST_n=0: reset wins and start is dropped.
- Reset mid-operation: the next edge returns to IDLE and clears all outputs. No done is produced.
- Wrap-around: the sum is modulo 2^WIDTH. The overflowed carry appears only on C_out.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=16, A=0x0001, B=0x0002, SUB=0, C_in=1, start pulse at edge T -> busy=1 from T+1; done=1 one cycle after edge T+5; SUM=0x0004, C_out=0, OVF=0.
- A=0xFFFF, B=0xFFFF, SUB=0, C_in=1 -> SUM=0xFFFF, C_out=1, OVF=0. Confirms the carry ripples across all 4 nibble passes.
- A=0x7FFF, B=0x0001, SUB=0, C_in=0 -> SUM=0x8000, C_out=0, OVF=1. A second run with A=0x0005, B=0x0007, SUB=1 -> SUM=0xFFFE, C_out=0 (borrow), OVF=0.
- Start A=0x1234, B=0x1111, SUB=0, C_in=0. Re-assert start with A=0xFFFF, B=0xFFFF at T+2 and again in the DONE cycle -> both ignored; SUM=0x2345. The next start after done is accepted normally.
- Start an operation, drive RST_n=0 at edge T+2 -> busy=0, done stays 0, SUM=0, C_out=0, OVF=0 the next cycle. After release, A=0x00FF, B=0x0001, SUB=0, C_in=0 -> SUM=0x0100.
